// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front-end control blocks: sequencer states,
// address width and the default sequential fetch increment.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC_DEF = 32'd4;
  localparam int DRAIN_W = 4;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC value: JR, then J/JAL, then taken branch,
// then sequential increment. Also flags whether a redirect was chosen.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_INC = PC_INC_DEF
) (
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc_next,
  output logic              redirect
);

  always_comb begin
    pc_next  = pc_cur + PC_INC;
    redirect = 1'b0;
    if (jr) begin
      pc_next  = jr_target;
      redirect = 1'b1;
    end else if (jump) begin
      pc_next  = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      pc_next  = branch_target;
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter controller: run/step gating, stall handling, redirect
// selection and HALT drain for the MIPS fetch stage.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_INC       = PC_INC_DEF,
  parameter int                DRAIN_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PC_CUR,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  input  logic              JUMP,
  input  logic [ADDR_W-1:0] JUMP_TARGET,
  input  logic              JR,
  input  logic [ADDR_W-1:0] JR_TARGET,
  input  logic              HALT_INSTR,
  input  logic              DBG_MODE,
  input  logic              DBG_RUN,
  input  logic              DBG_STEP,
  output logic [ADDR_W-1:0] PC_NEXT,
  output logic              PC_CTRL,
  output logic              FLUSH_IF,
  output logic              HALTED,
  output logic [ADDR_W-1:0] CYCLE_COUNT,
  output state_e            DBG_STATE
);

  state_e             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               enabled;
  logic               accept_halt;
  logic               redirect;

  assign enabled     = !RESET && (state == ST_RUN || state == ST_STEP);
  assign accept_halt = enabled && !STALL && HALT_INSTR;
  assign DBG_STATE   = state;

  // Redirect requests are masked during reset so the PC input shows the
  // plain sequential value.
  pc_next_mux #(.PC_INC(PC_INC)) u_pc_next_mux (
    .pc_cur        (PC_CUR),
    .branch_taken  (BRANCH_TAKEN && !RESET),
    .branch_target (BRANCH_TARGET),
    .jump          (JUMP && !RESET),
    .jump_target   (JUMP_TARGET),
    .jr            (JR && !RESET),
    .jr_target     (JR_TARGET),
    .pc_next       (PC_NEXT),
    .redirect      (redirect)
  );

  assign PC_CTRL  = enabled && !STALL && !HALT_INSTR;
  assign FLUSH_IF = PC_CTRL && redirect;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_WAIT;
      drain_cnt   <= '0;
      HALTED      <= 1'b0;
      CYCLE_COUNT <= '0;
    end else begin
      if (enabled) CYCLE_COUNT <= CYCLE_COUNT + 32'd1;
      case (state)
        ST_WAIT: begin
          if (DBG_RUN && !DBG_MODE)      state <= ST_RUN;
          else if (DBG_STEP && DBG_MODE) state <= ST_STEP;
        end
        ST_RUN: begin
          if (accept_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        ST_STEP: begin
          if (accept_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
          end else begin
            state <= ST_WAIT;
          end
        end
        // The extra cycle spent at zero makes HALTED rise DRAIN_CYCLES+1
        // edges after the accepting edge.
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= ST_DONE;
            HALTED <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against an event-based
// reference model of run/step/halt behaviour.
module tb_pc_sequencer;
  import mips_pkg::*;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall;
  logic        br;
  logic [31:0] br_t;
  logic        jump;
  logic [31:0] jump_t;
  logic        jr;
  logic [31:0] jr_t;
  logic        halt;
  logic        dbg_mode;
  logic        dbg_run;
  logic        dbg_step;
  logic [31:0] pc_next;
  logic        pc_ctrl;
  logic        flush_if;
  logic        halted;
  logic [31:0] cycle_count;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: execution permission flags plus the edge at which HALT
  // was accepted; halted-ness is derived arithmetically from edge numbers.
  logic        run_on;
  logic        step_armed;
  int          halt_at;
  int          edge_n;
  logic [31:0] m_count;
  int          en_seen;

  pc_sequencer #(.PC_INC(32'd4), .DRAIN_CYCLES(DRAIN)) dut (
    .CLK(clk), .RESET(rst), .PC_CUR(pc_cur), .STALL(stall),
    .BRANCH_TAKEN(br), .BRANCH_TARGET(br_t), .JUMP(jump), .JUMP_TARGET(jump_t),
    .JR(jr), .JR_TARGET(jr_t), .HALT_INSTR(halt), .DBG_MODE(dbg_mode),
    .DBG_RUN(dbg_run), .DBG_STEP(dbg_step), .PC_NEXT(pc_next), .PC_CTRL(pc_ctrl),
    .FLUSH_IF(flush_if), .HALTED(halted), .CYCLE_COUNT(cycle_count),
    .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    run_on     = 1'b0;
    step_armed = 1'b0;
    halt_at    = -1;
    m_count    = '0;
  endtask

  function automatic logic exp_halted();
    return (halt_at >= 0) && (edge_n >= halt_at + DRAIN + 1);
  endfunction

  // One clock cycle: check combinational outputs against the current inputs,
  // take the edge, advance the model, check registered outputs, drop pulses.
  task automatic tick();
    logic        en;
    logic        e_ctrl;
    logic [31:0] e_next;
    logic        redir;
    #1;
    en     = !rst && (run_on || step_armed) && (halt_at < 0);
    e_ctrl = en && !stall && !halt;
    redir  = !rst && (jr || jump || br);
    if (rst || !(jr || jump || br)) e_next = pc_cur + 32'd4;
    else if (jr)                    e_next = jr_t;
    else if (jump)                  e_next = jump_t;
    else                            e_next = br_t;
    chk("pc_next", pc_next, e_next);
    chk("pc_ctrl", {31'd0, pc_ctrl}, {31'd0, e_ctrl});
    chk("flush_if", {31'd0, flush_if}, {31'd0, e_ctrl && redir});
    if (e_ctrl) en_seen++;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_reset();
    end else if (en) begin
      m_count++;
      if (!stall && halt) halt_at = edge_n;
      step_armed = 1'b0;
    end else if (halt_at < 0) begin
      if (dbg_run && !dbg_mode)  run_on = 1'b1;
      if (dbg_step && dbg_mode)  step_armed = 1'b1;
    end
    #1;
    chk("halted", {31'd0, halted}, {31'd0, exp_halted()});
    chk("cycle_count", cycle_count, m_count);
    dbg_run  = 1'b0;
    dbg_step = 1'b0;
  endtask

  task automatic quiet_inputs();
    stall = 0; br = 0; jump = 0; jr = 0; halt = 0;
    dbg_run = 0; dbg_step = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_cur = '0; br_t = '0; jump_t = '0; jr_t = '0; dbg_mode = 0;
    quiet_inputs();
    model_reset();
    edge_n = 0; en_seen = 0;

    // Reset state, with redirects asserted to show they are masked.
    jr = 1; jr_t = 32'h0000_1000; pc_cur = 32'h0000_0040;
    do_reset();
    jr = 0;

    // Continuous run from PC 0.
    pc_cur = 32'h0; dbg_mode = 0; dbg_run = 1;
    tick();
    repeat (3) tick();
    chk("run_count3", cycle_count, 32'd3);

    // All redirects together: JR wins; then a stalled branch is suppressed.
    jr = 1; jr_t = 32'h100; jump = 1; jump_t = 32'h200; br = 1; br_t = 32'h300;
    tick();
    jr = 0; jump = 0; stall = 1;
    tick();
    stall = 0; br = 0;

    // Sequential wrap.
    pc_cur = 32'hFFFF_FFFC;
    tick();

    // HALT in RUN, DBG_RUN during DONE ignored.
    halt = 1; tick(); halt = 0;
    for (int i = 0; i < 9; i++) begin
      pc_cur = $urandom;
      if (i == 7) dbg_run = 1;
      tick();
    end
    chk("halted_stays", {31'd0, halted}, 32'd1);

    // Single-step mode, pulses 4 cycles apart.
    do_reset();
    dbg_mode = 1; en_seen = 0;
    for (int p = 0; p < 3; p++) begin
      dbg_step = 1;
      repeat (4) tick();
    end
    chk("step_enables", en_seen, 32'd3);
    chk("step_count", cycle_count, 32'd3);
    dbg_mode = 0; dbg_step = 1; en_seen = 0;
    repeat (3) tick();
    chk("step_mode0", en_seen, 32'd0);

    // Asynchronous reset in the middle of DRAIN.
    dbg_run = 1; tick(); tick();
    halt = 1; tick(); halt = 0;
    tick(); tick();
    #2;
    do_reset();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      pc_cur   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      br_t     = $urandom; jump_t = $urandom; jr_t = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      br       = ($urandom_range(0, 3) == 0);
      jump     = ($urandom_range(0, 3) == 0);
      jr       = ($urandom_range(0, 3) == 0);
      halt     = ($urandom_range(0, 39) == 0);
      dbg_mode = $urandom_range(0, 1);
      dbg_run  = ($urandom_range(0, 7) == 0);
      dbg_step = ($urandom_range(0, 5) == 0);
      if (c % 90 == 89) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller for the MIPS program counter register. Each cycle it decides whether the PC loads (PC_CTRL) and with what value (PC_NEXT): sequential increment, branch, jump or jump-register target. It honours hazard stalls and drains the pipeline on a HALT instruction. It also implements the debug run/step gating used by the debug unit. It sits between the ID-stage control/hazard logic and the PC register in IF.

## Interface
Parameters:
- PC_INC, 4, byte increment for sequential fetch
- DRAIN_CYCLES, 4, cycles the PC stays frozen after HALT before HALTED asserts (range 1..15)

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- PC_CUR  in  32  current PC register value
- STALL  in  1  hazard unit: hold PC and IF/ID this cycle
- BRANCH_TAKEN  in  1  ID-stage branch resolved taken
- BRANCH_TARGET  in  32  branch target address
- JUMP  in  1  J/JAL in ID
- JUMP_TARGET  in  32  jump target address
- JR  in  1  JR/JALR in ID
- JR_TARGET  in  32  register jump target address
- HALT_INSTR  in  1  HALT opcode decoded in ID
- DBG_MODE  in  1  0 = continuous run, 1 = single-step
- DBG_RUN  in  1  one-cycle pulse: start execution
- DBG_STEP  in  1  one-cycle pulse: advance one cycle (step mode only)
- PC_NEXT  out  32  value for the PC register input
- PC_CTRL  out  1  PC load enable
- FLUSH_IF  out  1  squash the IF/ID instruction (redirect taken)
- HALTED  out  1  program finished, pipeline drained
- CYCLE_COUNT  out  32  count of enabled execution cycles

## Operation
- FSM states:
  - WAIT: reset state, PC frozen.
  - RUN: continuous execution.
  - STEP: exactly one enabled cycle.
  - DRAIN: PC frozen, counter running.
  - DONE: halted.
- WAIT transitions:
  - DBG_RUN with DBG_MODE=0 -> RUN.
  - DBG_STEP with DBG_MODE=1 -> STEP.
  - Otherwise stay in WAIT. DBG_STEP is ignored when DBG_MODE=0.
- STEP returns to WAIT after one cycle unless HALT_INSTR is accepted in that cycle (-> DRAIN).
- A cycle is "enabled" in RUN or STEP. In WAIT, DRAIN and DONE: PC_CTRL=0 and FLUSH_IF=0.
- Priority within an enabled cycle:
  - STALL=1: PC_CTRL=0, FLUSH_IF=0. All redirects and HALT_INSTR are ignored, because ID re-presents them next cycle.
  - HALT_INSTR=1: PC_CTRL=0, FLUSH_IF=0, next state DRAIN, drain counter loaded with DRAIN_CYCLES.
  - Otherwise PC_CTRL=1, and PC_NEXT is selected as: JR -> JR_TARGET, else JUMP -> JUMP_TARGET, else BRANCH_TAKEN -> BRANCH_TARGET, else PC_CUR+PC_INC.
  - FLUSH_IF=1 whenever a redirect (JR, JUMP or BRANCH_TAKEN) is selected.
- PC_NEXT always reflects the mux, independent of PC_CTRL. The PC_CUR+PC_INC addition is 32-bit modulo: 0xFFFFFFFC+4 wraps to 0x00000000.
- DRAIN: the counter decrements each cycle. When it reaches 0, go to DONE and set HALTED=1.
- DONE is absorbing; only RESET leaves it. DBG_RUN and DBG_STEP are ignored in DRAIN and DONE.
- CYCLE_COUNT increments by 1 on every enabled cycle, including stalled ones, and wraps at 2^32.
- DBG_RUN arriving while in RUN has no effect. DBG_MODE is sampled only in WAIT.

## Timing
- PC_NEXT, PC_CTRL and FLUSH_IF are combinational from the current state and inputs. The PC register updates on the same rising edge on which PC_CTRL is high: zero added latency.
- State, drain counter, HALTED and CYCLE_COUNT are registered.
- RESET (asynchronous) sets: state=WAIT, HALTED=0, CYCLE_COUNT=0, drain counter=0. While RESET is high: PC_CTRL=0, FLUSH_IF=0, PC_NEXT=PC_CUR+PC_INC.
- RESET mid-DRAIN or in DONE returns to WAIT immediately.
- HALTED rises exactly DRAIN_CYCLES+1 edges after the edge on which HALT_INSTR was accepted.
- A step of N DBG_STEP pulses yields exactly N enabled cycles, provided the pulses are at least 2 cycles apart. A pulse arriving while in STEP is ignored.

## Structure
- Shared package mips_pkg holds:
  - the state enum (WAIT, RUN, STEP, DRAIN, DONE)
  - the PC_INC default
  - the 32-bit address width constant
- One natural sub-module: pc_next_mux. It is the combinational priority mux producing PC_NEXT and the redirect flag. The FSM, counters and gating stay in pc_sequencer.

## Test plan
- Reset, then DBG_MODE=0 and a DBG_RUN pulse with PC_CUR=0x00000000 -> PC_CTRL=1, PC_NEXT=0x00000004. CYCLE_COUNT=3 after 3 enabled cycles.
- In RUN, assert JR=1 (JR_TARGET=0x100), JUMP=1 (0x200) and BRANCH_TAKEN=1 (0x300) together -> PC_NEXT=0x100, FLUSH_IF=1. Then STALL=1 with BRANCH_TAKEN=1 -> PC_CTRL=0, FLUSH_IF=0.
- DBG_MODE=1, three DBG_STEP pulses 4 cycles apart -> exactly 3 cycles with PC_CTRL=1 and CYCLE_COUNT=3. A DBG_STEP with DBG_MODE=0 -> no enable.
- HALT_INSTR=1 in RUN, DRAIN_CYCLES=4 -> PC_CTRL=0 from that cycle on. HALTED=1 five edges later and stays high. DBG_RUN afterwards has no effect.
- Assert RESET asynchronously during DRAIN -> HALTED=0, CYCLE_COUNT=0, state WAIT immediately.
- PC_CUR=0xFFFFFFFC, no redirect -> PC_NEXT=0x00000000.
